bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter and master-side multiplexer for the shared system bus.
//  Sits directly downstream of the bus_if instances (IF and MEM stages, plus up to two other masters).
//  Consumes each master's bus_req_/bus_addr/bus_as_/bus_rw/bus_wr_data and returns bus_grnt_.
//  Drives the single selected master's request onto the slave side of the bus.
// PARAMETERS
//  ADDR_W   30  word address width (`WORD_ADDR_W)
//  DATA_W   32  data width (`WORD_DATA_W)
// PORTS
//  clk            input   1       system clock
//  reset          input   1       asynchronous, active-high reset
//  m{0..3}_req_   input   1       master n bus request, active-low
//  m{0..3}_addr   input   ADDR_W  master n word address
//  m{0..3}_as_    input   1       master n address strobe, active-low
//  m{0..3}_rw     input   1       master n `READ/`WRITE
//  m{0..3}_wr_data input  DATA_W  master n write data
//  m{0..3}_grnt_  output  1       master n bus grant, active-low, registered
//  s_addr         output  ADDR_W  selected master address to slaves
//  s_as_          output  1       selected master strobe to slaves
//  s_rw           output  1       selected master rw to slaves
//  s_wr_data      output  DATA_W  selected master write data to slaves
// BEHAVIOUR
//  - State: owner register, 2 bits; exactly one master owns the bus at all times (bus parking).
//  - Reset (async, immediate):
//    - owner = master 0, so the boot fetch needs no arbitration cycle.
//    - m0_grnt_ = `ENABLE_; m1..m3_grnt_ = `DISABLE_.
//  - grnt_ outputs are decoded from owner: owner==n -> mn_grnt_ low. Exactly one grant is low, never zero or two.
//  - Hold: while the current owner's req_ is `ENABLE_ at a rising edge, owner is unchanged. There is no preemption and no timeout.
//  - Release: owner's req_ sampled `DISABLE_ at rising edge N.
//    - The new owner is the first requesting master in order owner+1, owner+2, owner+3 (mod 4).
//    - The new owner is loaded at edge N; its grant is visible in cycle N+1, so handover latency is 1 cycle.
//    - If no other master requests, owner is unchanged (parked); the parked master may re-request with zero-cycle grant.
//  - Simultaneous requests at release: the rotation order above decides. The previous owner has lowest priority.
//  - Wrap-around: owner 3 releasing searches 0, 1, 2.
//  - Slave-side mux is combinational from owner; s_* = m[owner]_*.
//    - During reset, s_* follow master 0 inputs.
//    - A non-owner's as_ never reaches s_as_.
//  - Bus reply (rd_data, rdy_) is broadcast by the slave side and is not routed here. Masters qualify it with their own grant.
//  - Reset mid-transaction: grant returns to master 0 at once. The aborted master's bus_if is reset by the same signal.
// STRUCTURE
//  - bus.h gains:
//    - `BUS_MASTER_CH 4
//    - `BUS_OWNER_BUS [1:0]
//    - `BUS_OWNER_MASTER_0..3
//    - These use the existing `ENABLE_/`DISABLE_, `READ/`WRITE, `WORD_ADDR_BUS and `WORD_DATA_BUS.
//  - One sub-module: bus_master_mux (pure 4:1 combinational select of addr/as_/rw/wr_data by owner).
//  - The owner FSM and grant decode stay in bus_arbiter.
// TESTING
//  1. Reset pulse, all req_ high -> m0_grnt_=0, m1..3_grnt_=1; s_addr=m0_addr (e.g. 30'h1).
//  2. Owner 0 holds req_ low 10 cycles while m1,m2 request -> grant stays on m0 all 10 cycles; s_wr_data=m0_wr_data.
//  3. m0 releases at edge N while m2,m3 request -> m2_grnt_=0 in cycle N+1; s_addr=m2_addr (e.g. 30'h98).
//  4. Owner 3 releases, m0 and m2 request -> owner 0 (wrap-around); next release by m0 -> m2.
//  5. Owner 1 releases, nobody requests -> m1_grnt_ stays 0; m1 re-requests -> granted with no idle cycle.
//  6. Assert reset mid-cycle with owner 2, s_as_=0 -> m0_grnt_=0 before the next edge; s_as_ follows m0_as_.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus arbitration constants, owner type and rotation helper
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_t;

  // First requester in order cur+1, cur+2, cur+3; keeps cur when nobody else asks.
  function automatic bus_owner_t next_owner(input bus_owner_t cur,
                                            input logic [BUS_MASTER_CH-1:0] req_n);
    logic [1:0] idx;
    next_owner = cur;
    for (int i = BUS_MASTER_CH - 1; i >= 1; i--) begin
      idx = 2'(cur) + 2'(i);
      if (req_n[idx] == ENABLE_) next_owner = bus_owner_t'(idx);
    end
  endfunction

endpackage

// File: rtl/bus_master_mux.sv
// rtl/bus_master_mux.sv - combinational 4:1 select of the owning master's request onto the slave side
module bus_master_mux
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  bus_owner_t        owner,
  input  logic [ADDR_W-1:0] addr    [BUS_MASTER_CH],
  input  logic              as_n    [BUS_MASTER_CH],
  input  logic              rw      [BUS_MASTER_CH],
  input  logic [DATA_W-1:0] wr_data [BUS_MASTER_CH],
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data
);

  assign s_addr    = addr[owner];
  assign s_as_     = as_n[owner];
  assign s_rw      = rw[owner];
  assign s_wr_data = wr_data[owner];

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin parking arbiter for four bus masters with slave-side mux
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_as_,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_grnt_,
  input  logic              m1_req_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_as_,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_grnt_,
  input  logic              m2_req_,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic              m2_as_,
  input  logic              m2_rw,
  input  logic [DATA_W-1:0] m2_wr_data,
  output logic              m2_grnt_,
  input  logic              m3_req_,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m3_as_,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic              m3_grnt_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data
);

  bus_owner_t                owner, owner_nxt;
  logic [BUS_MASTER_CH-1:0]  grnt_n, grnt_n_nxt;
  logic [BUS_MASTER_CH-1:0]  req_n;

  logic [ADDR_W-1:0] addr_v    [BUS_MASTER_CH];
  logic              as_v      [BUS_MASTER_CH];
  logic              rw_v      [BUS_MASTER_CH];
  logic [DATA_W-1:0] wr_data_v [BUS_MASTER_CH];

  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

  assign addr_v[0] = m0_addr;    assign addr_v[1] = m1_addr;
  assign addr_v[2] = m2_addr;    assign addr_v[3] = m3_addr;
  assign as_v[0]   = m0_as_;     assign as_v[1]   = m1_as_;
  assign as_v[2]   = m2_as_;     assign as_v[3]   = m3_as_;
  assign rw_v[0]   = m0_rw;      assign rw_v[1]   = m1_rw;
  assign rw_v[2]   = m2_rw;      assign rw_v[3]   = m3_rw;
  assign wr_data_v[0] = m0_wr_data;  assign wr_data_v[1] = m1_wr_data;
  assign wr_data_v[2] = m2_wr_data;  assign wr_data_v[3] = m3_wr_data;

  // Grants are flopped alongside the owner so they come straight from registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= BUS_OWNER_MASTER_0;
      grnt_n <= 4'b1110;
    end else begin
      owner  <= owner_nxt;
      grnt_n <= grnt_n_nxt;
    end
  end

  always_comb begin
    owner_nxt = owner;
    if (req_n[owner] == DISABLE_) owner_nxt = next_owner(owner, req_n);
    grnt_n_nxt = {BUS_MASTER_CH{DISABLE_}};
    grnt_n_nxt[owner_nxt] = ENABLE_;
  end

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

  bus_master_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner     (owner),
    .addr      (addr_v),
    .as_n      (as_v),
    .rw        (rw_v),
    .wr_data   (wr_data_v),
    .s_addr    (s_addr),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for the round-robin bus arbiter
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_n;
  logic [3:0]  as_n;
  logic [29:0] addr [4];
  logic [31:0] wdata [4];
  logic [3:0]  rw;
  logic [3:0]  grnt_n;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;

  typedef struct {
    logic [3:0]  grnt;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        as_;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks_total = 0;
  int   checks_pass  = 0;
  int   m_owner;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m0_addr(addr[0]), .m0_as_(as_n[0]), .m0_rw(rw[0]),
    .m0_wr_data(wdata[0]), .m0_grnt_(grnt_n[0]),
    .m1_req_(req_n[1]), .m1_addr(addr[1]), .m1_as_(as_n[1]), .m1_rw(rw[1]),
    .m1_wr_data(wdata[1]), .m1_grnt_(grnt_n[1]),
    .m2_req_(req_n[2]), .m2_addr(addr[2]), .m2_as_(as_n[2]), .m2_rw(rw[2]),
    .m2_wr_data(wdata[2]), .m2_grnt_(grnt_n[2]),
    .m3_req_(req_n[3]), .m3_addr(addr[3]), .m3_as_(as_n[3]), .m3_rw(rw[3]),
    .m3_wr_data(wdata[3]), .m3_grnt_(grnt_n[3]),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks_total++;
    if (got === want) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic exp_t expect_for(input int own);
    exp_t e;
    e.grnt  = 4'b1111;
    e.grnt[own] = 1'b0;
    e.addr  = addr[own];
    e.wdata = wdata[own];
    e.as_   = as_n[own];
    e.rw    = rw[own];
    return e;
  endfunction

  // Drive one cycle of requests at the falling edge, predict, then compare at the next falling edge.
  task automatic cycle(input logic [3:0] r, input string tag);
    exp_t e;
    bit   found;
    req_n = r;
    as_n  = r;
    if (r[m_owner]) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && !r[(m_owner + k) % 4]) begin
          m_owner = (m_owner + k) % 4;
          found   = 1'b1;
        end
      end
    end
    sb.push_back(expect_for(m_owner));
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".grnt"},  64'(grnt_n),    64'(e.grnt));
    check({tag, ".addr"},  64'(s_addr),    64'(e.addr));
    check({tag, ".wdata"}, 64'(s_wr_data), 64'(e.wdata));
    check({tag, ".as"},    64'(s_as_),     64'(e.as_));
    check({tag, ".rw"},    64'(s_rw),      64'(e.rw));
  endtask

  initial begin
    addr[0] = 30'h1;   addr[1] = 30'h55;  addr[2] = 30'h98;  addr[3] = 30'h3c3;
    wdata[0] = 32'hd000_0000; wdata[1] = 32'hd111_1111;
    wdata[2] = 32'hd222_2222; wdata[3] = 32'hd333_3333;
    rw    = 4'b1010;
    req_n = 4'b1111;
    as_n  = 4'b1111;
    reset = 1'b1;
    m_owner = 0;

    @(negedge clk);
    @(negedge clk);
    check("rst.grnt", 64'(grnt_n), 64'he);
    check("rst.addr", 64'(s_addr), 64'h1);
    reset = 1'b0;

    cycle(4'b1111, "idle0");
    cycle(4'b1111, "idle1");

    for (int i = 0; i < 10; i++) cycle(4'b1000, "hold0");

    cycle(4'b0011, "rel0_to2");
    check("rel0_to2.addr98", 64'(s_addr), 64'h98);
    cycle(4'b0010, "hold2");
    cycle(4'b0111, "rel2_to3");
    cycle(4'b1010, "wrap3_to0");
    cycle(4'b1011, "rel0_to2b");
    cycle(4'b1101, "rel2_to1");
    cycle(4'b1111, "park1");
    cycle(4'b1111, "park1b");
    cycle(4'b1101, "rereq1");

    for (int i = 0; i < 40; i++) cycle(4'($urandom_range(0, 15)), "rand");

    cycle(4'b1101, "to1");
    cycle(4'b1011, "to2");
    check("pre_rst.owner2", 64'(grnt_n), 64'hb);
    check("pre_rst.as", 64'(s_as_), 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst.grnt", 64'(grnt_n), 64'he);
    check("midrst.as_follows_m0", 64'(s_as_), 64'(as_n[0]));
    as_n[0] = 1'b0;
    #1;
    check("midrst.as_m0_low", 64'(s_as_), 64'h0);
    check("midrst.addr", 64'(s_addr), 64'h1);
    @(negedge clk);
    reset   = 1'b0;
    m_owner = 0;
    cycle(4'b1110, "post_rst");

    check("sb.empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
